rsi_engine_scheduler: RTL
=========================

# rsi_engine_scheduler

Round-robin scheduler that shares one `rsi_fsm` RSI engine between `NUM_CH` price channels. Each channel's `WINDOW`-sample price window lives in an external synchronous price RAM at base address `ch*WINDOW`. On a request, the block grants one channel and pulses the engine's `start`. It then replays that channel's window into the engine with a `new_price` strobe every second cycle, waits for `done`, and publishes the RSI tagged with the channel number. It sits between the price-capture RAM and the results/alert logic.

## Interface
- `NUM_CH`, 4, number of requesting channels (2..16)
- `WINDOW`, 20, prices replayed per job (≥2)
- `PRICE_W`, 16, price width
- `ADDR_W`, 7, price RAM address width; `NUM_CH*WINDOW ≤ 2**ADDR_W`
- `CH_W`, `$clog2(NUM_CH)` (min 1), channel index width
- `TIMEOUT`, 255, `WAIT_DONE` watchdog limit in cycles (used only with `RSI_SCHED_TIMEOUT_EN`)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req` in `NUM_CH`: per-channel request pulses or levels, sampled every cycle
- `rd_en` out 1: price RAM read enable
- `rd_addr` out `ADDR_W`: price RAM address
- `rd_data` in `PRICE_W`: RAM data, valid the cycle after `rd_en`
- `eng_start` out 1: engine start pulse
- `eng_price` out `PRICE_W`: price to engine
- `eng_new_price` out 1: price strobe
- `eng_done` in 1: engine done, level or pulse
- `eng_rsi` in 8: engine RSI result
- `busy` out 1: a job is in progress (any state except `IDLE`)
- `grant_ch` out `CH_W`: channel currently served
- `result_valid` out 1: one-cycle result strobe
- `result_ch` out `CH_W`: channel of the result
- `result_rsi` out 8: RSI value
- `result_err` out 1: job aborted by timeout

## Operation
- `pending[NUM_CH]` is sticky. Bit c is set whenever `req[c]`=1 and cleared at grant of channel c. If set and clear occur in the same cycle, set wins.
- Arbitration is round-robin. The search starts at `last_grant+1` and wraps. `last_grant` resets to `NUM_CH-1`, so channel 0 has first priority.
- FSM states:
  - `IDLE` → `START` when `pending`≠0. `grant_ch` and the base address are latched in this cycle.
  - `START` (1 cycle): `eng_start`=1, `rd_en`=1, `rd_addr`=base. → `GAP`.
  - `GAP`: `eng_new_price`=0. `rd_data` is registered into `eng_price`. → `STROBE`.
  - `STROBE`: `eng_new_price`=1 with `eng_price`=price[k]. If k<`WINDOW-1`, issue read base+k+1. Increment k, then go to `GAP`. After k=`WINDOW-1`, go to `WAIT_DONE`.
  - `WAIT_DONE`: `eng_done` is sampled only in this state. On 1, capture `eng_rsi` → `RESULT`.
  - `RESULT` (1 cycle): `result_valid`=1 with `result_ch`=`grant_ch` and `result_rsi` = the captured value. Update `last_grant`. → `IDLE`.
- `eng_start`, `eng_new_price`, `rd_en` and `result_valid` are single-cycle pulses. All outputs are registered.
- `result_ch`, `result_rsi` and `result_err` hold their values until the next `RESULT`.
- Reset, including mid-job: state → `IDLE`; `pending`=0; every output 0. No partial result is emitted, and the engine shares `rst`.

## Timing
- Take S = the `START` cycle. Strobe k occurs at S+2+2k, for k = 0..`WINDOW-1`. Read of k+1 is issued at S+2+2k.
- The last strobe is at S+2·`WINDOW`. `WAIT_DONE` begins at S+2·`WINDOW`+1.
- `RESULT` is at D+1, where D is the first `WAIT_DONE` cycle with `eng_done`=1. `IDLE` is at D+2.
- Turnaround is 1 cycle: a request pending at D+2 gives `START` at D+3.
- Minimum job length is 2·`WINDOW`+4 cycles, plus engine latency.
- A request raised in cycle t is visible to arbitration at t+1.

## Configuration
- `RSI_SCHED_TIMEOUT_EN` defined:
  - A counter runs in `WAIT_DONE`.
  - If `eng_done` is absent for `TIMEOUT` cycles, go to `RESULT` with `result_err`=1 and `result_rsi`=0.
  - The round-robin pointer still advances.
- `RSI_SCHED_TIMEOUT_EN` undefined:
  - `WAIT_DONE` waits indefinitely.
  - `result_err` is tied 0 and no counter is built.

## Test plan
- Single job: one-cycle `req[2]` pulse, with RAM words 40..59 holding 100, 98, 101, 99, … (alternating −2/+3).
  - Addresses 40..59 are read in order.
  - Strobes occur at S+2+2k.
  - The response is `result_ch`=2, and `result_rsi` equals the reference-engine value, at D+1.
- Arbitration order: `req`=4'b1111 for one cycle → results in order 0, 1, 2, 3. Then `req[1]` and `req[3]` together → order 1, 3.
- Re-request: `req[0]` held high throughout → channel 0 is served back-to-back, each `START` at D+3 of the prior job. With `req[1]` also pending, order is 0, 1, 0, 1.
- Reset mid-feed: `rst` at strobe 5 → all outputs 0 asynchronously, no `result_valid`, `pending`=0. After release and a new `req[3]`, a clean job runs from address 60.
- Timeout (`RSI_SCHED_TIMEOUT_EN`, `TIMEOUT`=50, stub engine never done) → `result_valid` with `result_err`=1 and `result_rsi`=0 exactly 51 cycles after `WAIT_DONE` entry.
- Done glitch: `eng_done` pulsed during `STROBE` → ignored; a result is produced only after `eng_done` arrives in `WAIT_DONE`.

Source files
------------

// File: rtl/rsi_engine_scheduler.sv
// Round-robin scheduler sharing one RSI engine across NUM_CH price channels, replaying each window from price RAM.
// Optional macro RSI_SCHED_TIMEOUT_EN adds a WAIT_DONE watchdog that aborts a job after TIMEOUT cycles.
module rsi_engine_scheduler #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned WINDOW  = 20,
    parameter int unsigned PRICE_W = 16,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_CH-1:0]  req,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [PRICE_W-1:0] rd_data,
    output logic               eng_start,
    output logic [PRICE_W-1:0] eng_price,
    output logic               eng_new_price,
    input  logic               eng_done,
    input  logic [7:0]         eng_rsi,
    output logic               busy,
    output logic [CH_W-1:0]    grant_ch,
    output logic               result_valid,
    output logic [CH_W-1:0]    result_ch,
    output logic [7:0]         result_rsi,
    output logic               result_err
);

    localparam int unsigned K_W = $clog2(WINDOW);

    if (NUM_CH < 2 || WINDOW < 2 || NUM_CH * WINDOW > (1 << ADDR_W) || TIMEOUT == 0) begin : g_cfg_check
        $error("rsi_engine_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_STROBE,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [CH_W-1:0]     grant_ch_q, grant_ch_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                eng_start_q, eng_start_d;
    logic [PRICE_W-1:0]  eng_price_q, eng_price_d;
    logic                eng_new_price_q, eng_new_price_d;
    logic                busy_q, busy_d;
    logic                result_valid_q, result_valid_d;
    logic [CH_W-1:0]     result_ch_q, result_ch_d;
    logic [7:0]          result_rsi_q, result_rsi_d;

    logic                arb_hit_c;
    logic [CH_W-1:0]     arb_ch_c;
    logic [CH_W:0]       arb_sum_c;
    logic [CH_W-1:0]     arb_idx_c;
    logic [NUM_CH-1:0]   clr_c;

`ifdef RSI_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                result_err_q, result_err_d;
`endif

    // Round-robin search starting one past the last served channel, wrapping at NUM_CH.
    always_comb begin
        arb_hit_c = 1'b0;
        arb_ch_c  = '0;
        arb_sum_c = '0;
        arb_idx_c = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            arb_sum_c = {1'b0, last_grant_q} + (CH_W+1)'(i);
            if (arb_sum_c >= (CH_W+1)'(NUM_CH)) begin
                arb_sum_c = arb_sum_c - (CH_W+1)'(NUM_CH);
            end
            arb_idx_c = CH_W'(arb_sum_c);
            if (!arb_hit_c && pending_q[arb_idx_c]) begin
                arb_hit_c = 1'b1;
                arb_ch_c  = arb_idx_c;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_ch_d      = grant_ch_q;
        base_d          = base_q;
        k_d             = k_q;
        rd_en_d         = 1'b0;
        rd_addr_d       = rd_addr_q;
        eng_start_d     = 1'b0;
        eng_price_d     = eng_price_q;
        eng_new_price_d = 1'b0;
        result_valid_d  = 1'b0;
        result_ch_d     = result_ch_q;
        result_rsi_d    = result_rsi_q;
        clr_c           = '0;
`ifdef RSI_SCHED_TIMEOUT_EN
        tmo_d           = '0;
        result_err_d    = result_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (arb_hit_c) begin
                    state_d         = S_START;
                    grant_ch_d      = arb_ch_c;
                    base_d          = ADDR_W'(32'(arb_ch_c) * WINDOW);
                    k_d             = '0;
                    clr_c[arb_ch_c] = 1'b1;
                    eng_start_d     = 1'b1;
                    rd_en_d         = 1'b1;
                    rd_addr_d       = ADDR_W'(32'(arb_ch_c) * WINDOW);
                end
            end
            S_START: begin
                state_d = S_GAP;
            end
            S_GAP: begin
                // RAM word k is on rd_data now; present it with the strobe and prefetch k+1.
                state_d         = S_STROBE;
                eng_price_d     = rd_data;
                eng_new_price_d = 1'b1;
                if (k_q != K_W'(WINDOW - 1)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + ADDR_W'(k_q) + ADDR_W'(1);
                end
            end
            S_STROBE: begin
                k_d = k_q + K_W'(1);
                if (k_q == K_W'(WINDOW - 1)) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_WAIT_DONE: begin
`ifdef RSI_SCHED_TIMEOUT_EN
                tmo_d = tmo_q + TMO_W'(1);
`endif
                if (eng_done) begin
                    state_d        = S_RESULT;
                    result_valid_d = 1'b1;
                    result_ch_d    = grant_ch_q;
                    result_rsi_d   = eng_rsi;
`ifdef RSI_SCHED_TIMEOUT_EN
                    result_err_d   = 1'b0;
                end else if (tmo_q == TMO_W'(TIMEOUT)) begin
                    state_d        = S_RESULT;
                    result_valid_d = 1'b1;
                    result_ch_d    = grant_ch_q;
                    result_rsi_d   = '0;
                    result_err_d   = 1'b1;
`endif
                end
            end
            S_RESULT: begin
                state_d      = S_IDLE;
                last_grant_d = grant_ch_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request arriving in the grant cycle re-arms the channel (set wins over clear).
        pending_d = (pending_q & ~clr_c) | req;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            pending_q       <= '0;
            last_grant_q    <= CH_W'(NUM_CH - 1);
            grant_ch_q      <= '0;
            base_q          <= '0;
            k_q             <= '0;
            rd_en_q         <= 1'b0;
            rd_addr_q       <= '0;
            eng_start_q     <= 1'b0;
            eng_price_q     <= '0;
            eng_new_price_q <= 1'b0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_ch_q     <= '0;
            result_rsi_q    <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            last_grant_q    <= last_grant_d;
            grant_ch_q      <= grant_ch_d;
            base_q          <= base_d;
            k_q             <= k_d;
            rd_en_q         <= rd_en_d;
            rd_addr_q       <= rd_addr_d;
            eng_start_q     <= eng_start_d;
            eng_price_q     <= eng_price_d;
            eng_new_price_q <= eng_new_price_d;
            busy_q          <= busy_d;
            result_valid_q  <= result_valid_d;
            result_ch_q     <= result_ch_d;
            result_rsi_q    <= result_rsi_d;
        end
    end

`ifdef RSI_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q        <= '0;
            result_err_q <= 1'b0;
        end else begin
            tmo_q        <= tmo_d;
            result_err_q <= result_err_d;
        end
    end

    assign result_err = result_err_q;
`else
    assign result_err = 1'b0;
`endif

    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;
    assign eng_start     = eng_start_q;
    assign eng_price     = eng_price_q;
    assign eng_new_price = eng_new_price_q;
    assign busy          = busy_q;
    assign grant_ch      = grant_ch_q;
    assign result_valid  = result_valid_q;
    assign result_ch     = result_ch_q;
    assign result_rsi    = result_rsi_q;

endmodule
